// File: rtl/foo_bar_stim_gen.sv
// rtl/foo_bar_stim_gen.sv - registered walking-zero foo/bar stimulus source for the per-bit checker
module foo_bar_stim_gen #(
    parameter int WIDTH      = 12,
    parameter int CHECK_BITS = 10,
    parameter int HOLD       = 1,
    localparam int SW        = (CHECK_BITS > 1) ? $clog2(CHECK_BITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] foo,
    output logic [WIDTH-1:0] bar,
    output logic [SW-1:0]    step_idx,
    output logic             expect_fail
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(CHECK_BITS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    // Bad parameters must stop elaboration rather than produce a silently wrong sweep.
    if (CHECK_BITS < 1 || CHECK_BITS > WIDTH || HOLD < 1) begin : g_param_check
        $error("foo_bar_stim_gen: need 1 <= CHECK_BITS <= WIDTH and HOLD >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SW-1:0]      step_d;
    logic [SW-1:0]      step_nx;
    logic               busy_d, done_d, fail_d;
    logic [WIDTH-1:0]   foo_d, bar_d;
    logic [CHECK_BITS-1:0] fb_low;

    // All ones except a single zero at bit s; s stays below CHECK_BITS so the
    // unchecked upper bits are always ones.
    function automatic logic [WIDTH-1:0] walk_zero(input logic [SW-1:0] s);
        walk_zero = ~({{(WIDTH-1){1'b0}}, 1'b1} << s);
    endfunction

    // Mode bit 0 selects the walking zero on foo, mode bit 1 on bar.
    function automatic logic [WIDTH-1:0] foo_pat(input logic [1:0] m, input logic [SW-1:0] s);
        foo_pat = m[0] ? walk_zero(s) : {WIDTH{1'b1}};
    endfunction

    function automatic logic [WIDTH-1:0] bar_pat(input logic [1:0] m, input logic [SW-1:0] s);
        bar_pat = m[1] ? walk_zero(s) : {WIDTH{1'b1}};
    endfunction

    assign step_nx = step_idx + SW'(1);
    assign fb_low  = foo[CHECK_BITS-1:0] & bar[CHECK_BITS-1:0];

    // Next state and next registered outputs; every output is a flop so the
    // checker sees glitch-free vectors.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        step_d  = step_idx;
        busy_d  = busy;
        done_d  = 1'b0;
        foo_d   = foo;
        bar_d   = bar;
        fail_d  = expect_fail;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                foo_d  = {WIDTH{1'b1}};
                bar_d  = {WIDTH{1'b1}};
                step_d = '0;
                fail_d = 1'b0;
                hold_d = '0;
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    busy_d  = 1'b1;
                    foo_d   = foo_pat(mode, '0);
                    bar_d   = bar_pat(mode, '0);
                    fail_d  = (mode != 2'd0);
                end
            end
            S_RUN: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (step_idx == LAST_STEP) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        foo_d   = {WIDTH{1'b1}};
                        bar_d   = {WIDTH{1'b1}};
                        step_d  = '0;
                        fail_d  = 1'b0;
                    end else begin
                        step_d = step_nx;
                        foo_d  = foo_pat(mode_q, step_nx);
                        bar_d  = bar_pat(mode_q, step_nx);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                foo_d   = {WIDTH{1'b1}};
                bar_d   = {WIDTH{1'b1}};
                step_d  = '0;
                fail_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                foo_d   = {WIDTH{1'b1}};
                bar_d   = {WIDTH{1'b1}};
                step_d  = '0;
                fail_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            hold_q      <= '0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            foo         <= {WIDTH{1'b1}};
            bar         <= {WIDTH{1'b1}};
            expect_fail <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            step_idx    <= step_d;
            busy        <= busy_d;
            done        <= done_d;
            foo         <= foo_d;
            bar         <= bar_d;
            expect_fail <= fail_d;
        end
    end

    a_done_after_busy: assert property (@(posedge clk) disable iff (rst) done |-> $past(busy));
    a_busy_done_excl:  assert property (@(posedge clk) disable iff (rst) !(busy && done));
    a_fail_flag:       assert property (@(posedge clk) disable iff (rst)
                           (state_q == S_RUN) |-> ((&fb_low) == !expect_fail));

endmodule

// File: tb/tb_foo_bar_stim_gen.sv
// tb/tb_foo_bar_stim_gen.sv - scoreboard bench for foo_bar_stim_gen at HOLD=1 and HOLD=3
module tb_foo_bar_stim_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          done;
        logic [11:0] foo;
        logic [11:0] bar;
        int          step;
        bit          ef;
    } exp_t;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int HG = (g == 0) ? 1 : 3;
        localparam int L  = 10 * HG;

        logic        busy, done, ef;
        logic [11:0] foo, bar;
        logic [3:0]  step;

        foo_bar_stim_gen #(.WIDTH(12), .CHECK_BITS(10), .HOLD(HG)) u_dut (
            .clk(clk),
            .rst(rst),
            .start(start),
            .mode(mode),
            .busy(busy),
            .done(done),
            .foo(foo),
            .bar(bar),
            .step_idx(step),
            .expect_fail(ef)
        );

        exp_t sb[$];
        int   edge_n  = 0;
        int   next_ok = 0;

        // Reference model: a start accepted at edge E yields 10 steps of HG
        // cycles each, visible from edge E, then a done cycle at E+L; the next
        // start can be taken no earlier than edge E+L+2.
        always @(posedge clk) begin
            exp_t e;
            edge_n = edge_n + 1;
            if (rst) begin
                while (sb.size() > 0 && sb[$].cyc >= edge_n) void'(sb.pop_back());
                next_ok = edge_n + 1;
            end else if (start && edge_n >= next_ok) begin
                for (int s = 0; s < 10; s++) begin
                    for (int k = 0; k < HG; k++) begin
                        e.cyc  = edge_n + s * HG + k;
                        e.done = 1'b0;
                        e.step = s;
                        e.ef   = (mode != 2'd0);
                        e.foo  = (mode == 2'd1 || mode == 2'd3) ? 12'(4095 - (1 << s)) : 12'hFFF;
                        e.bar  = (mode == 2'd2 || mode == 2'd3) ? 12'(4095 - (1 << s)) : 12'hFFF;
                        sb.push_back(e);
                    end
                end
                e.cyc  = edge_n + L;
                e.done = 1'b1;
                e.step = 0;
                e.ef   = 1'b0;
                e.foo  = 12'hFFF;
                e.bar  = 12'hFFF;
                sb.push_back(e);
                next_ok = edge_n + L + 2;
            end
        end

        // Monitor: every cycle either matches the scheduled entry or the idle vector.
        always @(negedge clk) begin
            exp_t        e;
            logic [30:0] act;
            logic [30:0] want;
            if (edge_n > 0) begin
                act = {busy, done, foo, bar, step, ef};
                if (sb.size() > 0 && sb[0].cyc == edge_n) begin
                    e    = sb.pop_front();
                    want = {!e.done, e.done, e.foo, e.bar, 4'(e.step), e.ef};
                end else begin
                    want = {1'b0, 1'b0, 12'hFFF, 12'hFFF, 4'd0, 1'b0};
                end
                checks = checks + 1;
                if (act !== want) begin
                    errors = errors + 1;
                    $display("FAIL hold%0d outputs cycle %0d {busy,done,foo,bar,step,ef}: got %h required %h",
                             HG, edge_n, act, want);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = 2'($urandom);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        mode  = 2'd0;
        repeat (3) tick();
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) tick();

        pulse(2'd0);
        repeat (35) tick();
        pulse(2'd1);
        repeat (35) tick();
        pulse(2'd3);
        repeat (35) tick();

        pulse(2'd2);
        repeat (3) tick();
        start = 1'b1;
        mode  = 2'($urandom);
        tick();
        start = 1'b0;
        repeat (35) tick();

        pulse(2'($urandom));
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (35) tick();

        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            mode = 2'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (35) tick();

        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 7) == 0);
            mode  = 2'($urandom);
            rst   = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (40) tick();

        checks = checks + 1;
        if (g_inst[0].sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL hold1 leftover: got %0d pending entries required 0", g_inst[0].sb.size());
        end
        checks = checks + 1;
        if (g_inst[1].sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL hold3 leftover: got %0d pending entries required 0", g_inst[1].sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/foo_bar_stim_gen.md
Name: foo_bar_stim_gen

Overview:
- Registered stimulus source that drives the 12-bit foo/bar vector pair consumed by the per-bit immediate/concurrent assertion checker (foo[i] && bar[i], i = 0..9).
- On a start request it steps through the checked bit positions and emits one pattern per step: all-ones (pass), or a walking zero on foo, bar or both (forced fail).
- It flags every vector the checker must reject.
- It sits at the front of the checker bench as the producer end of the foo/bar interface.

Parameters:
- WIDTH, 12, width of foo and bar.
- CHECK_BITS, 10, number of low-order bit positions the checker tests; legal range 1..WIDTH.
- HOLD, 1, clock cycles each step's vector is held; must be at least 1.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a run; sampled only in IDLE.
- mode  input  2  pattern select, latched with start: 0=ALL_ONES, 1=WALK0_FOO, 2=WALK0_BAR, 3=WALK0_BOTH.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse after the last step.
- foo  output  WIDTH  stimulus vector A.
- bar  output  WIDTH  stimulus vector B.
- step_idx  output  $clog2(CHECK_BITS) (min 1)  current bit position under test.
- expect_fail  output  1  high when the current foo/bar pair must fail the checker.

Behaviour:
- All outputs are registered and driven directly from state registers.
- Reset, and IDLE/DONE outputs:
  - Reset values: state=IDLE, busy=0, done=0, foo='1, bar='1, step_idx=0, expect_fail=0, hold counter=0, latched mode=0.
  - IDLE and DONE outputs: foo=bar=all ones, expect_fail=0, step_idx=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at posedge k: latch mode, go to RUN, clear step_idx and hold counter.
  - The first step-0 vector is visible after edge k, with busy=1 from that edge.
- RUN:
  - Pattern for step s (bit s zero, all other bits one):
    - ALL_ONES: foo=bar='1.
    - WALK0_FOO: foo zero at bit s; bar='1.
    - WALK0_BAR: bar zero at bit s; foo='1.
    - WALK0_BOTH: foo and bar both zero at bit s.
  - Bits CHECK_BITS..WIDTH-1 are always 1 in every mode.
  - expect_fail = (latched mode != 0) throughout RUN.
  - Hold counter counts 0..HOLD-1.
  - At HOLD-1: if s == CHECK_BITS-1, go to DONE; else s = s+1 and the counter clears.
  - busy is high for exactly CHECK_BITS*HOLD cycles.
- DONE:
  - Lasts exactly one cycle with done=1 and busy=0, then returns to IDLE.
  - The earliest next run is start sampled in the following IDLE cycle.
- start while RUN or DONE is ignored; mode changes during RUN have no effect.
- step_idx never wraps within a run; it returns to 0 only via IDLE or DONE.
- rst=1 in any state, including mid-RUN: next edge forces the full reset values, no done pulse, and the aborted run is not resumed.
- rst and start high together: rst wins.
- Parameter sanity: elaboration-time assertion that 1 <= CHECK_BITS <= WIDTH and HOLD >= 1.
- Embedded checks, disabled during rst:
  - done implies a prior cycle had busy=1.
  - busy and done are never high together.
  - In RUN, (foo & bar)[CHECK_BITS-1:0] == all ones iff expect_fail == 0.

Test Plan:
- Reset: hold rst 3 cycles with start=1 -> foo=bar=12'hFFF, busy=0, done=0, expect_fail=0 throughout and after release.
- ALL_ONES, defaults: start=1, mode=0 for one cycle -> busy high 10 cycles, foo=bar=12'hFFF each cycle, step_idx 0..9, expect_fail=0; done pulses on cycle 11; back in IDLE on cycle 12.
- WALK0_FOO: mode=1 -> foo = 12'hFFE, 12'hFFD, 12'hFFB, ..., 12'hDFF, bar=12'hFFF, expect_fail=1 each step; bits 10 and 11 stay 1.
- WALK0_BOTH with HOLD=3: mode=3 -> each step lasts 3 cycles with foo==bar (zero at step_idx); busy is 30 cycles total.
- Ignored start / abort:
  - start pulsed at step 4 of a mode=2 run -> no restart; the run completes normally.
  - rst asserted at step 6 -> outputs all ones next edge, no done pulse.
- Back-to-back: start held high continuously -> runs separated by exactly one DONE cycle plus one IDLE cycle; mode re-latched each run.
